axi_lite_rd_arbiter: RTL and testbench
======================================

AXI_LITE_RD_ARBITER -- requirements
Module: axi_lite_rd_arbiter

Interface
REQ-001 The block SHALL have a parameter AW, default 32, giving the read address width.
REQ-002 The block SHALL have a parameter DW, default 64, giving the read data width.
REQ-003 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_arvalid/m0_arready/m0_araddr  in/out/in  1/1/AW  master 0 (instruction fetch) read-address channel.
REQ-006 m0_rvalid/m0_rready/m0_rdata/m0_rresp  out/in/out/out  1/1/DW/2  master 0 read-data channel.
REQ-007 m1_arvalid/m1_arready/m1_araddr  in/out/in  1/1/AW  master 1 (load/store unit) read-address channel.
REQ-008 m1_rvalid/m1_rready/m1_rdata/m1_rresp  out/in/out/out  1/1/DW/2  master 1 read-data channel.
REQ-009 s_arvalid/s_arready/s_araddr  out/in/out  1/1/AW  shared slave read-address channel.
REQ-010 s_rvalid/s_rready/s_rdata/s_rresp  in/out/in/in  1/1/DW/2  shared slave read-data channel.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 gnt_id  output  1  index of the currently or most recently granted master.

Function
REQ-013 The FSM SHALL have the states IDLE, ADDR and DATA.
REQ-014 IDLE: when any mX_arvalid is high, the block SHALL latch the winner into gnt_id and move to ADDR on the next edge; with no request it SHALL remain in IDLE.
REQ-015 ADDR: s_arvalid SHALL equal 1 and s_araddr SHALL equal the granted master's araddr.
REQ-016 ADDR: the granted master's arready SHALL equal s_arready; on s_arvalid&s_arready the FSM SHALL move to DATA.
REQ-017 DATA: the granted master's rvalid/rdata/rresp SHALL equal s_rvalid/s_rdata/s_rresp, and s_rready SHALL equal the granted master's rready.
REQ-018 DATA: on s_rvalid&s_rready the FSM SHALL return to IDLE.
REQ-019 Latency: grant to s_arvalid is exactly one cycle after arvalid is seen in IDLE; the back-to-back turnaround is one IDLE cycle.
REQ-020 The non-granted master, and both masters in IDLE, SHALL see arready=0 and rvalid=0; in IDLE, DATA and reset, s_arvalid SHALL be 0.
REQ-021 In IDLE and ADDR, s_rready SHALL be 0.
REQ-022 mX_rdata and mX_rresp SHALL be driven with s_rdata/s_rresp at all times; validity is qualified by rvalid only.
REQ-023 The grant SHALL be fixed for the whole AR+R transaction; a master dropping arvalid in ADDR SHALL NOT abort the transaction, because s_arvalid stays high until the handshake completes.
REQ-024 When both masters request in the same IDLE cycle, the winner SHALL follow REQ-028/REQ-029.
REQ-025 A request arriving on the same edge that the FSM returns to IDLE SHALL be arbitrated in the following cycle.

Reset
REQ-026 While rst is high: state=IDLE, gnt_id=0, busy=0, and all valid/ready outputs 0; the round-robin pointer SHALL be set to 1 (master 0 favoured next).
REQ-027 A reset asserted in ADDR or DATA SHALL abandon the transaction; no response is forwarded after reset.

Configuration
REQ-028 With ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie the master not granted last wins, and the pointer updates at each grant.
REQ-029 Without ARB_RR_EN, arbitration SHALL be fixed-priority with master 1 (load/store) always winning ties; no pointer register exists.

Verification
REQ-030 Only m0 requests addr 0x80000000, slave returns arready after 2 cycles and rdata 0x00000413 after 3 cycles -> m0_rvalid with data 0x413, m1 idle, busy returns to 0.
REQ-031 m0 and m1 request in the same cycle (0x80000004 / 0x80001000), macro off -> s_araddr=0x80001000 first, then 0x80000004.
REQ-032 Macro on, both masters hold arvalid for 4 transactions -> gnt_id sequence 0,1,0,1.
REQ-033 Granted master holds rready=0 for 3 cycles while s_rvalid=1 -> s_rready=0, FSM stays in DATA, and the data is accepted on the first rready=1.
REQ-034 rst pulsed in DATA -> next cycle state=IDLE, all valids 0, a late s_rvalid is not forwarded, and a new m1 request is served normally.
REQ-035 m1 arvalid arrives on the return-to-IDLE edge -> granted one cycle later with s_arvalid high, and no lost or duplicated transfer.

Source files
------------

// File: rtl/axi_lite_rd_if.sv
// AXI-Lite read channel (AR + R) bundle shared by the masters and the slave of the read arbiter.
// The master modport drives the request side; the slave modport drives the response side.
interface axi_lite_rd_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master AXI-Lite read arbiter: one AR+R transaction at a time on a shared slave port.
// Define ARB_RR_EN for round-robin tie breaking; otherwise master 1 (load/store) wins ties.
module axi_lite_rd_arbiter #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic           clk,
    input  logic           rst,
    axi_lite_rd_if.slave   m0,
    axi_lite_rd_if.slave   m1,
    axi_lite_rd_if.master  s,
    output logic           busy,
    output logic           gnt_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;
    logic          any_req_s;
    logic          winner_s;
    logic          gnt_rready_s;
    logic          in_addr_s;
    logic          in_data_s;
    logic [AW-1:0] gnt_addr_s;
    logic [DW-1:0] rdata_s;
`ifdef ARB_RR_EN
    logic          rr_last_q, rr_last_d;
`endif

    // Arbitration between the two read-address requests
    always_comb begin
        any_req_s = m0.arvalid | m1.arvalid;
`ifdef ARB_RR_EN
        if (m0.arvalid && m1.arvalid) begin
            winner_s = ~rr_last_q;
        end else begin
            winner_s = m1.arvalid;
        end
`else
        winner_s = m1.arvalid;
`endif
    end

    // Granted master's request-side signals
    always_comb begin
        gnt_rready_s = gnt_id_q ? m1.rready : m0.rready;
        gnt_addr_s   = gnt_id_q ? m1.araddr : m0.araddr;
    end

    // Next-state logic; the grant is frozen from ADDR until the R handshake
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
`ifdef ARB_RR_EN
        rr_last_d = rr_last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d  = ST_ADDR;
                    gnt_id_d = winner_s;
`ifdef ARB_RR_EN
                    rr_last_d = winner_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (s.arready) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (s.rvalid && gnt_rready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, grant and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ARB_RR_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
`ifdef ARB_RR_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    // Channel steering; handshakes are masked during reset so nothing leaks mid-abort
    always_comb begin
        in_addr_s  = (state_q == ST_ADDR) && !rst;
        in_data_s  = (state_q == ST_DATA) && !rst;
        rdata_s    = s.rdata;

        s.arvalid  = in_addr_s;
        s.araddr   = gnt_addr_s;
        s.rready   = in_data_s & gnt_rready_s;

        m0.arready = in_addr_s & ~gnt_id_q & s.arready;
        m1.arready = in_addr_s &  gnt_id_q & s.arready;
        m0.rvalid  = in_data_s & ~gnt_id_q & s.rvalid;
        m1.rvalid  = in_data_s &  gnt_id_q & s.rvalid;

        m0.rdata   = rdata_s;
        m1.rdata   = rdata_s;
        m0.rresp   = s.rresp;
        m1.rresp   = s.rresp;

        busy       = busy_q & ~rst;
        gnt_id     = gnt_id_q & ~rst;
    end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Directed + randomized bench for axi_lite_rd_arbiter, checked against a transaction-level model.
// Honours ARB_RR_EN for the expected tie-break order.
module tb_axi_lite_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic gnt_id;

    axi_lite_rd_if #(.AW(AW), .DW(DW)) m0_if ();
    axi_lite_rd_if #(.AW(AW), .DW(DW)) m1_if ();
    axi_lite_rd_if #(.AW(AW), .DW(DW)) s_if ();

    axi_lite_rd_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .m0     (m0_if),
        .m1     (m1_if),
        .s      (s_if),
        .busy   (busy),
        .gnt_id (gnt_id)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model: who owns the shared port and whether its address was accepted
    int            owner;
    bit            ar_done;
    bit            exp_gnt;
    bit            rr_last;
    bit            ar_hs [2];
    int            want [2];
    int            issued [2];
    int            done_cnt [2];
    logic [AW-1:0] base [2];
    logic [AW-1:0] ar_addr_q [$];
    bit            gnt_q [$];
    logic [DW-1:0] last_rdata;
    bit            fast;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input bit r0, input bit r1);
`ifdef ARB_RR_EN
        if (r0 && r1) return (rr_last == 1'b1) ? 1'b0 : 1'b1;
        return r1;
`else
        return r1 ? 1'b1 : 1'b0;
`endif
    endfunction

    function automatic bit owner_rready(input int o);
        return (o == 1) ? m1_if.rready : m0_if.rready;
    endfunction

    task automatic idle_inputs();
        m0_if.arvalid = 1'b0; m0_if.araddr = 32'h0; m0_if.rready = 1'b0;
        m1_if.arvalid = 1'b0; m1_if.araddr = 32'h0; m1_if.rready = 1'b0;
        s_if.arready  = 1'b0; s_if.rvalid  = 1'b0;
        s_if.rdata    = 64'h0; s_if.rresp  = 2'b00;
    endtask

    task automatic clear_stats();
        done_cnt[0] = 0; done_cnt[1] = 0;
        issued[0] = 0;   issued[1] = 0;
        ar_addr_q.delete();
        gnt_q.delete();
    endtask

    // One clock: check outputs mid-cycle, advance the model, return just after the next edge
    task automatic cyc();
        bit in_addr;
        bit in_data;
        @(negedge clk);
        ar_hs[0] = 1'b0; ar_hs[1] = 1'b0;
        if (rst) begin
            chk("rst_busy", busy, 64'd0);
            chk("rst_gnt", gnt_id, 64'd0);
            chk("rst_s_arvalid", s_if.arvalid, 64'd0);
            chk("rst_s_rready", s_if.rready, 64'd0);
            chk("rst_m0_arready", m0_if.arready, 64'd0);
            chk("rst_m1_arready", m1_if.arready, 64'd0);
            chk("rst_m0_rvalid", m0_if.rvalid, 64'd0);
            chk("rst_m1_rvalid", m1_if.rvalid, 64'd0);
            owner = -1; ar_done = 1'b0; exp_gnt = 1'b0; rr_last = 1'b1;
        end else begin
            in_addr = (owner >= 0) && !ar_done;
            in_data = (owner >= 0) && ar_done;
            chk("busy", busy, (owner >= 0));
            chk("gnt_id", gnt_id, exp_gnt);
            chk("s_arvalid", s_if.arvalid, in_addr);
            if (in_addr)
                chk("s_araddr", s_if.araddr, (owner == 1) ? m1_if.araddr : m0_if.araddr);
            chk("m0_arready", m0_if.arready, (in_addr && owner == 0) ? s_if.arready : 1'b0);
            chk("m1_arready", m1_if.arready, (in_addr && owner == 1) ? s_if.arready : 1'b0);
            chk("s_rready", s_if.rready, in_data ? owner_rready(owner) : 1'b0);
            chk("m0_rvalid", m0_if.rvalid, (in_data && owner == 0) ? s_if.rvalid : 1'b0);
            chk("m1_rvalid", m1_if.rvalid, (in_data && owner == 1) ? s_if.rvalid : 1'b0);
            chk("m0_rdata", m0_if.rdata, s_if.rdata);
            chk("m1_rdata", m1_if.rdata, s_if.rdata);
            chk("m0_rresp", m0_if.rresp, s_if.rresp);
            chk("m1_rresp", m1_if.rresp, s_if.rresp);
            if (owner < 0) begin
                if (m0_if.arvalid || m1_if.arvalid) begin
                    owner   = pick(m0_if.arvalid, m1_if.arvalid);
                    exp_gnt = owner[0];
                    rr_last = owner[0];
                    ar_done = 1'b0;
                end
            end else if (!ar_done) begin
                if (s_if.arready) begin
                    ar_done = 1'b1;
                    ar_hs[owner] = 1'b1;
                    ar_addr_q.push_back(s_if.araddr);
                    gnt_q.push_back(gnt_id);
                end
            end else if (s_if.rvalid && owner_rready(owner)) begin
                done_cnt[owner]++;
                last_rdata = (owner == 1) ? m1_if.rdata : m0_if.rdata;
                owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Behavioural masters and slave for the agent-driven phases
    task automatic agents();
        bit hold;
        for (int i = 0; i < 2; i++) begin
            if (ar_hs[i]) begin
                want[i]--;
                issued[i]++;
            end
        end
        m0_if.arvalid = (want[0] > 0);
        m0_if.araddr  = base[0] + 32'(issued[0] * 4);
        m1_if.arvalid = (want[1] > 0);
        m1_if.araddr  = base[1] + 32'(issued[1] * 4);
        if (!fast && !ar_done && owner == 0 && $urandom_range(0, 7) == 0) m0_if.arvalid = 1'b0;
        if (!fast && !ar_done && owner == 1 && $urandom_range(0, 7) == 0) m1_if.arvalid = 1'b0;
        m0_if.rready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        m1_if.rready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        s_if.arready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        hold = (owner >= 0) && ar_done && s_if.rvalid;
        if (!hold) begin
            s_if.rvalid = fast ? 1'b1 : 1'($urandom_range(0, 1));
            s_if.rdata  = {$urandom, $urandom};
            s_if.rresp  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic run_agents(input int budget);
        int n;
        n = 0;
        do begin
            agents();
            cyc();
            n++;
        end while ((want[0] != 0 || want[1] != 0 || owner >= 0) && n < budget);
        chk("run_complete", (want[0] == 0 && want[1] == 0 && owner < 0), 64'd1);
        idle_inputs();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle_inputs();
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    initial begin
        int w0;
        int w1;
        rst = 1'b1;
        idle_inputs();
        owner = -1; ar_done = 1'b0; exp_gnt = 1'b0; rr_last = 1'b1;
        want[0] = 0; want[1] = 0;
        ar_hs[0] = 1'b0; ar_hs[1] = 1'b0;
        last_rdata = 64'h0;
        fast = 1'b1;
        clear_stats();

        // Reset with noisy inputs: nothing may be forwarded
        s_if.rvalid = 1'b1; s_if.arready = 1'b1; m0_if.arvalid = 1'b1; m1_if.rready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        idle_inputs();
        cyc();

        // Lone m0 fetch, slow slave
        clear_stats();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0000;
        cyc();
        chk("t030_sarvalid", s_if.arvalid, 64'd1);
        cyc(); cyc();
        s_if.arready = 1'b1;
        cyc();
        m0_if.arvalid = 1'b0; s_if.arready = 1'b0; m0_if.rready = 1'b1;
        cyc(); cyc();
        s_if.rvalid = 1'b1; s_if.rdata = 64'h413;
        cyc();
        chk("t030_rdata", last_rdata, 64'h413);
        chk("t030_count", done_cnt[0], 64'd1);
        chk("t030_m1_count", done_cnt[1], 64'd0);
        chk("t030_busy_after", busy, 64'd0);
        idle_inputs();
        cyc();

        // Simultaneous requests
        do_reset(1);
        clear_stats();
        fast = 1'b1;
        base[0] = 32'h8000_0004; base[1] = 32'h8000_1000;
        want[0] = 1; want[1] = 1;
        run_agents(200);
        chk("t031_n", ar_addr_q.size(), 64'd2);
`ifdef ARB_RR_EN
        chk("t031_first", ar_addr_q[0], 64'h8000_0004);
        chk("t031_second", ar_addr_q[1], 64'h8000_1000);
`else
        chk("t031_first", ar_addr_q[0], 64'h8000_1000);
        chk("t031_second", ar_addr_q[1], 64'h8000_0004);
`endif

        // Both masters holding arvalid for four transactions
        do_reset(1);
        clear_stats();
        base[0] = 32'h0000_1000; base[1] = 32'h0000_2000;
        want[0] = 2; want[1] = 2;
        run_agents(200);
        chk("t032_n", gnt_q.size(), 64'd4);
`ifdef ARB_RR_EN
        chk("t032_g0", gnt_q[0], 64'd0);
        chk("t032_g1", gnt_q[1], 64'd1);
        chk("t032_g2", gnt_q[2], 64'd0);
        chk("t032_g3", gnt_q[3], 64'd1);
`else
        chk("t032_g0", gnt_q[0], 64'd1);
        chk("t032_g1", gnt_q[1], 64'd1);
        chk("t032_g2", gnt_q[2], 64'd0);
        chk("t032_g3", gnt_q[3], 64'd0);
`endif

        // Master back-pressures the read data
        clear_stats();
        m1_if.arvalid = 1'b1; m1_if.araddr = 32'h0000_0044;
        cyc();
        s_if.arready = 1'b1;
        cyc();
        m1_if.arvalid = 1'b0; s_if.arready = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 64'hDEAD_BEEF_0000_1234; m1_if.rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t033_busy", busy, 64'd1);
            chk("t033_s_rready", s_if.rready, 64'd0);
        end
        m1_if.rready = 1'b1;
        cyc();
        chk("t033_rdata", last_rdata, 64'hDEAD_BEEF_0000_1234);
        chk("t033_count", done_cnt[1], 64'd1);
        idle_inputs();
        cyc();

        // Reset while in DATA
        clear_stats();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_0100;
        cyc();
        s_if.arready = 1'b1;
        cyc();
        m0_if.arvalid = 1'b0; s_if.arready = 1'b0; m0_if.rready = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 64'h55;
        cyc();
        chk("t034_late_rvalid", m0_if.rvalid, 64'd0);
        chk("t034_busy", busy, 64'd0);
        s_if.rvalid = 1'b0; m0_if.rready = 1'b0;
        m1_if.arvalid = 1'b1; m1_if.araddr = 32'h0000_0200;
        cyc();
        chk("t034_sarvalid", s_if.arvalid, 64'd1);
        chk("t034_saddr", s_if.araddr, 64'h200);
        s_if.arready = 1'b1;
        cyc();
        m1_if.arvalid = 1'b0; s_if.arready = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 64'h77; m1_if.rready = 1'b1;
        cyc();
        chk("t034_rdata", last_rdata, 64'h77);
        chk("t034_m0_count", done_cnt[0], 64'd0);
        chk("t034_m1_count", done_cnt[1], 64'd1);
        idle_inputs();
        cyc();

        // Request arriving on the return-to-IDLE edge
        clear_stats();
        m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_0300;
        cyc();
        s_if.arready = 1'b1;
        cyc();
        m0_if.arvalid = 1'b0; s_if.arready = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 64'h99; m0_if.rready = 1'b1;
        cyc();
        s_if.rvalid = 1'b0;
        m1_if.arvalid = 1'b1; m1_if.araddr = 32'h0000_0400;
        chk("t035_idle", busy, 64'd0);
        cyc();
        chk("t035_gnt", gnt_id, 64'd1);
        chk("t035_sarvalid", s_if.arvalid, 64'd1);
        s_if.arready = 1'b1;
        cyc();
        m1_if.arvalid = 1'b0; s_if.arready = 1'b0;
        s_if.rvalid = 1'b1; s_if.rdata = 64'hAA; m1_if.rready = 1'b1;
        cyc();
        chk("t035_m0_count", done_cnt[0], 64'd1);
        chk("t035_m1_count", done_cnt[1], 64'd1);
        chk("t035_ar_count", ar_addr_q.size(), 64'd2);
        idle_inputs();
        cyc();

        // Randomized traffic with a slow, noisy slave and wobbly masters
        fast = 1'b0;
        for (int r = 0; r < 6; r++) begin
            clear_stats();
            w0 = int'($urandom_range(0, 6));
            w1 = int'($urandom_range(1, 6));
            want[0] = w0; want[1] = w1;
            base[0] = $urandom & 32'hFFFF_FFF0;
            base[1] = $urandom & 32'hFFFF_FFF0;
            run_agents(3000);
            chk("rand_m0_count", done_cnt[0], w0);
            chk("rand_m1_count", done_cnt[1], w1);
            chk("rand_ar_count", ar_addr_q.size(), w0 + w1);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
